alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised WIDTH-bit integer execution unit: the single-cycle ALU op set plus iterative signed multiply and divide.
- Valid/ready handshake on input and output; all results and flags are registered.
- Sits between the register-read stage and writeback in the processor datapath.
- Multiply/divide stall the unit; ALU ops complete in one cycle.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept an operation.
- data_operandA  in  WIDTH  operand A.
- data_operandB  in  WIDTH  operand B.
- ctrl_ALUopcode  in  5  operation select.
- ctrl_shiftamt  in  SHW  shift amount.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer accepts the result.
- data_result  out  WIDTH  result.
- isNotEqual  out  1  A != B.
- isLessThan  out  1  signed A < B.
- overflow  out  1  signed overflow or exception.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, data_result=0, isNotEqual=0, isLessThan=0, overflow=0, counter=0. in_ready is forced to 0 while reset_n is low.
- A reset mid-operation aborts the operation; no result is produced.
- Opcodes:
  - 00000 ADD.
  - 00001 SUB.
  - 00010 AND.
  - 00011 OR.
  - 00100 SLL (logical left shift by ctrl_shiftamt).
  - 00101 SRA (arithmetic right shift by ctrl_shiftamt).
  - 00110 MUL (signed, low WIDTH bits).
  - 00111 DIV (signed, truncates toward zero).
  - Any other opcode: result 0, overflow 0, single-cycle.
- Acceptance: in_valid && in_ready at a rising edge. in_ready = (state==IDLE) && (!out_valid || out_ready), so a new op may be accepted on the same edge that the previous result is consumed.
- Operand capture: operands and opcode are captured at acceptance. Later input changes have no effect.
- States: IDLE, MUL, DIV, DONE.
  - IDLE: on accept of an ALU op, load the result registers and set out_valid on the same edge (latency 1), staying in IDLE. On accept of MUL → MUL; DIV → DIV; counter=0.
  - MUL: shift-add on operand magnitudes, one bit per cycle. After WIDTH iterations → DONE.
  - DIV: restoring division on magnitudes, one quotient bit per cycle. After WIDTH iterations → DONE.
  - DONE: apply sign correction, load the result registers, set out_valid → IDLE.
  - MUL/DIV latency: out_valid rises WIDTH+1 edges after the accept edge. in_ready=0 throughout.
- Output hold: while out_valid && !out_ready, data_result and all flags are held. out_valid clears on out_ready unless a new single-cycle result loads on that same edge.
- Flags: isNotEqual and isLessThan are computed from A−B for every opcode and registered with the result.
- isLessThan must be correct under subtraction overflow: it equals sign(A−B) XOR overflow_sub.
- Overflow by opcode:
  - ADD/SUB: standard signed overflow (operand signs vs result sign).
  - AND/OR/SLL/SRA: 0.
  - MUL: 1 if the full 2·WIDTH signed product does not fit in WIDTH bits.
  - DIV: 1 on B=0 (result 0) and on A=MIN, B=−1 (result MIN); otherwise 0.
- Shifts: shift amounts 0..WIDTH−1 only. SRA replicates the MSB.
- Arithmetic wrap: ADD/SUB results wrap modulo 2^WIDTH.

Test Plan:
1. WIDTH=32, ADD 0x7FFFFFFF+0x00000001 → out_valid one cycle after accept, result 0x80000000, overflow=1. ADD 0x80000000+0x80000000 → 0x00000000, overflow=1.
2. SUB 0x80000001−0x7FFFFFFF → result 0x00000002, overflow=1, isLessThan=1, isNotEqual=1. SUB 0x0FFFFFFF−0xFFFFFFFF → isLessThan=0. SUB 0−0 → isNotEqual=0, overflow=0.
3. MUL −3×7 → in_ready low 33 cycles, out_valid 33 edges after accept, result 0xFFFFFFEB, overflow=0. MUL 0x00010000×0x00010000 → result 0x00000000, overflow=1.
4. DIV −7/2 → 0xFFFFFFFD. DIV 5/0 → result 0, overflow=1. DIV 0x80000000/0xFFFFFFFF → result 0x80000000, overflow=1.
5. Backpressure: hold out_ready=0 after an OR 0xF0F0F0F0|0x0F0F0F0F result → result 0xFFFFFFFF held and in_ready=0 for 5 cycles. Raise out_ready with in_valid high → result consumed and next op accepted on the same edge.
6. Reset and width:
   - Assert reset_n=0 at cycle 10 of a MUL → out_valid=0 and all outputs 0 immediately.
   - After release, ADD 2+3 → 5.
   - WIDTH=8 build: SLL 0x01 by 7 → 0x80; SRA 0x80 by 3 → 0xF0; MUL latency 9 edges.

Source files
------------

// File: rtl/alu_multicycle.sv
// WIDTH-bit execution unit: single-cycle ALU ops plus iterative signed MUL/DIV,
// with registered results and flags behind a valid/ready handshake.
module alu_multicycle #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    // Handshake: an op is accepted when in_valid && in_ready at a rising edge;
    // a result is consumed when out_valid && out_ready at a rising edge.
    state_t               state;
    logic [SHW-1:0]       counter;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 div_op;
    logic                 sign_neg;
    logic [WIDTH-1:0]     mag;
    logic [2*WIDTH-1:0]   acc;

    logic                 accept;
    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     dif;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_ov;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_s;
    logic [WIDTH-1:0]     done_res;
    logic                 done_ov;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Returns {not_equal, less_than}; less_than stays correct when A-B overflows.
    function automatic logic [1:0] cmp_flags(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] d;
        logic             v;
        d = a - b;
        v = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
        return {a != b, d[WIDTH-1] ^ v};
    endfunction

    assign in_ready = reset_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum     = data_operandA + data_operandB;
        dif     = data_operandA - data_operandB;
        alu_res = '0;
        alu_ov  = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                alu_res = sum;
                alu_ov  = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                          (sum[WIDTH-1] != data_operandA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif;
                alu_ov  = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                          (dif[WIDTH-1] != data_operandA[WIDTH-1]);
            end
            OP_AND:  alu_res = data_operandA & data_operandB;
            OP_OR:   alu_res = data_operandA | data_operandB;
            OP_SLL:  alu_res = data_operandA << ctrl_shiftamt;
            OP_SRA:  alu_res = WIDTH'($signed(data_operandA) >>> ctrl_shiftamt);
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: upper half accumulates, lower half drains the multiplier.
    always_comb begin
        mul_sum  = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag})
                          : {1'b0, acc[2*WIDTH-1:WIDTH]};
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // One restoring step: upper half is the remainder, lower half dividend/quotient.
    always_comb begin
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial     = rem_shift - {1'b0, mag};
        div_next  = trial[WIDTH] ? {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod_s = sign_neg ? -acc : acc;
        quo_s  = sign_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        if (div_op) begin
            if (b_q == '0) begin
                done_res = '0;
                done_ov  = 1'b1;
            end else if (a_q == MIN_VAL && b_q == '1) begin
                done_res = MIN_VAL;
                done_ov  = 1'b1;
            end else begin
                done_res = quo_s;
                done_ov  = 1'b0;
            end
        end else begin
            done_res = prod_s[WIDTH-1:0];
            done_ov  = prod_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod_s[WIDTH-1]}};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            counter     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            div_op      <= 1'b0;
            sign_neg    <= 1'b0;
            mag         <= '0;
            acc         <= '0;
            out_valid   <= 1'b0;
            data_result <= '0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q      <= data_operandA;
                        b_q      <= data_operandB;
                        div_op   <= (ctrl_ALUopcode == OP_DIV);
                        sign_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        counter  <= '0;
                        if (ctrl_ALUopcode == OP_MUL) begin
                            acc       <= {{WIDTH{1'b0}}, magnitude(data_operandB)};
                            mag       <= magnitude(data_operandA);
                            out_valid <= 1'b0;
                            state     <= MUL;
                        end else if (ctrl_ALUopcode == OP_DIV) begin
                            acc       <= {{WIDTH{1'b0}}, magnitude(data_operandA)};
                            mag       <= magnitude(data_operandB);
                            out_valid <= 1'b0;
                            state     <= DIV;
                        end else begin
                            data_result              <= alu_res;
                            overflow                 <= alu_ov;
                            {isNotEqual, isLessThan} <= cmp_flags(data_operandA, data_operandB);
                            out_valid                <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    acc     <= (state == MUL) ? mul_next : div_next;
                    counter <= counter + SHW'(1);
                    if (counter == SHW'(WIDTH - 1)) begin
                        counter <= '0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    data_result              <= done_res;
                    overflow                 <= done_ov;
                    {isNotEqual, isLessThan} <= cmp_flags(a_q, b_q);
                    out_valid                <= 1'b1;
                    state                    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: a 32-bit instance checked against an
// arithmetic model through an expected queue, plus an 8-bit instance.
module tb_alu_multicycle;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    // clock / reset
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [4:0]  ctrl_ALUopcode = '0;
    logic [4:0]  ctrl_shiftamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] data_result;
    logic        isNotEqual, isLessThan, overflow;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [4:0]  op8 = '0;
    logic [2:0]  sh8 = '0;
    logic        out_valid8;
    logic [7:0]  res8;
    logic        ne8, lt8, ov8;

    alu_multicycle #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_result(data_result), .isNotEqual(isNotEqual),
        .isLessThan(isLessThan), .overflow(overflow)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .data_operandA(a8), .data_operandB(b8),
        .ctrl_ALUopcode(op8), .ctrl_shiftamt(sh8),
        .out_valid(out_valid8), .out_ready(1'b1),
        .data_result(res8), .isNotEqual(ne8),
        .isLessThan(lt8), .overflow(ov8)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        ne;
        logic        lt;
        logic        ov;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic fits32(input longint v);
        return (v >= -(longint'(1) <<< 31)) && (v < (longint'(1) <<< 31));
    endfunction

    // Reference behaviour from plain signed integer arithmetic.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t   e;
        longint sa, sb, full;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        e.ne = (a != b);
        e.lt = (sa < sb);
        e.ov = 1'b0;
        e.res = '0;
        case (op)
            OP_ADD: begin full = sa + sb; e.res = full[31:0]; e.ov = !fits32(full); end
            OP_SUB: begin full = sa - sb; e.res = full[31:0]; e.ov = !fits32(full); end
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_SLL: e.res = 32'(a << sh);
            OP_SRA: e.res = 32'(sa >>> sh);
            OP_MUL: begin full = sa * sb; e.res = full[31:0]; e.ov = !fits32(full); end
            OP_DIV: begin
                if (b == 0) begin
                    e.res = '0; e.ov = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.res = 32'h8000_0000; e.ov = 1'b1;
                end else begin
                    full = sa / sb; e.res = full[31:0];
                end
            end
            default: e.res = '0;
        endcase
        return e;
    endfunction

    // scoreboard: every cycle a result is presented it must match the queue head
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0h required=none", data_result);
            end else begin
                e = exp_q[0];
                chk("sb_result", data_result, e.res);
                chk("sb_flags", {isNotEqual, isLessThan, overflow}, {e.ne, e.lt, e.ov});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    // driver: presents an op (caller is just past a rising edge), waits for acceptance
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output int waits);
        ctrl_ALUopcode = op;
        data_operandA  = a;
        data_operandB  = b;
        ctrl_shiftamt  = sh;
        in_valid       = 1'b1;
        waits          = 0;
        @(negedge clock);
        while (!in_ready && waits < 200) begin
            @(negedge clock);
            waits++;
        end
        chk("accept_ready", in_ready, 1);
        @(posedge clock);
        if (in_ready) exp_q.push_back(model(op, a, b, sh));
        #1;
        in_valid       = 1'b0;
        data_operandA  = $urandom();
        data_operandB  = $urandom();
        ctrl_ALUopcode = 5'($urandom_range(0, 31));
        ctrl_shiftamt  = 5'($urandom_range(0, 31));
    endtask

    // counts rising edges after the accept edge until out_valid is seen
    task automatic wait_result(output int edges, output int lows);
        edges = 0;
        lows  = 0;
        @(negedge clock);
        while (!out_valid && edges < 200) begin
            if (!in_ready) lows++;
            @(negedge clock);
            edges++;
        end
    endtask

    task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] exp_res, input logic exp_ov, input int exp_lat);
        int w, lat, lows;
        sync();
        issue(op, a, b, sh, w);
        wait_result(lat, lows);
        chk({name, "_res"}, data_result, exp_res);
        chk({name, "_ov"}, overflow, exp_ov);
        chk({name, "_lat"}, lat, exp_lat);
    endtask

    task automatic do8(input string name, input logic [4:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] sh,
                       input logic [7:0] exp_res, input logic exp_ov, input int exp_lat);
        int n;
        sync();
        op8 = op; a8 = a; b8 = b; sh8 = sh; in_valid8 = 1'b1;
        n = 0;
        @(negedge clock);
        while (!in_ready8 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_ready"}, in_ready8, 1);
        @(posedge clock);
        #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom());
        b8 = 8'($urandom());
        n = 0;
        @(negedge clock);
        while (!out_valid8 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_res"}, res8, exp_res);
        chk({name, "_ov"}, ov8, exp_ov);
        chk({name, "_lat"}, n, exp_lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat, lows;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", data_result, 0);
        chk("rst_flags", {isNotEqual, isLessThan, overflow}, 3'b000);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        do_op("add_ovf_pos", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 1'b1, 0);
        do_op("add_ovf_neg", OP_ADD, 32'h8000_0000, 32'h8000_0000, 0, 32'h0000_0000, 1'b1, 0);

        do_op("sub_ovf", OP_SUB, 32'h8000_0001, 32'h7FFF_FFFF, 0, 32'h0000_0002, 1'b1, 0);
        chk("sub_ovf_lt", isLessThan, 1);
        chk("sub_ovf_ne", isNotEqual, 1);
        do_op("sub_lt0", OP_SUB, 32'h0FFF_FFFF, 32'hFFFF_FFFF, 0, 32'h1000_0000, 1'b0, 0);
        chk("sub_lt0_lt", isLessThan, 0);
        do_op("sub_zero", OP_SUB, 32'h0, 32'h0, 0, 32'h0, 1'b0, 0);
        chk("sub_zero_ne", isNotEqual, 0);

        do_op("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 32'h00F0_1200, 1'b0, 0);
        do_op("sll31", OP_SLL, 32'h0000_0003, 32'h0, 5'd31, 32'h8000_0000, 1'b0, 0);
        do_op("sra4", OP_SRA, 32'h8000_0000, 32'h0, 5'd4, 32'hF800_0000, 1'b0, 0);
        do_op("sra0", OP_SRA, 32'h8765_4321, 32'h0, 5'd0, 32'h8765_4321, 1'b0, 0);
        do_op("bad_op", 5'b11111, 32'h7FFF_FFFF, 32'h1, 0, 32'h0, 1'b0, 0);

        sync();
        issue(OP_MUL, 32'hFFFF_FFFD, 32'h0000_0007, 0, w);
        wait_result(lat, lows);
        chk("mul_neg_res", data_result, 32'hFFFF_FFEB);
        chk("mul_neg_ov", overflow, 0);
        chk("mul_neg_lat", lat, 33);
        chk("mul_neg_busy", lows, 33);
        do_op("mul_ovf", OP_MUL, 32'h0001_0000, 32'h0001_0000, 0, 32'h0, 1'b1, 33);
        do_op("mul_min", OP_MUL, 32'h8000_0000, 32'h0000_0001, 0, 32'h8000_0000, 1'b0, 33);

        do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, 32'hFFFF_FFFD, 1'b0, 33);
        do_op("div_zero", OP_DIV, 32'h0000_0005, 32'h0, 0, 32'h0, 1'b1, 33);
        do_op("div_minm1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1'b1, 33);
        do_op("div_big", OP_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 0, 32'hF800_0001, 1'b0, 33);

        // backpressure: result held, then consumed on the same edge a new op enters
        sync();
        out_ready = 1'b0;
        issue(OP_OR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_hold_res", data_result, 32'hFFFF_FFFF);
            chk("bp_hold_ready", {out_valid, in_ready}, 2'b10);
        end
        sync();
        out_ready = 1'b1;
        issue(OP_ADD, 32'h1, 32'h1, 0, w);
        chk("bp_same_edge", w, 0);
        wait_result(lat, lows);
        chk("bp_next_res", data_result, 32'h2);
        chk("bp_next_lat", lat, 0);

        // reset in the middle of a multiply
        sync();
        issue(OP_MUL, 32'h0000_1234, 32'h0000_5678, 0, w);
        repeat (10) @(negedge clock);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_result", data_result, 0);
        chk("mid_rst_flags", {isNotEqual, isLessThan, overflow}, 3'b000);
        chk("mid_rst_ready", in_ready, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        do_op("post_rst_add", OP_ADD, 32'h2, 32'h3, 0, 32'h5, 1'b0, 0);

        do8("w8_sll", OP_SLL, 8'h01, 8'h00, 3'd7, 8'h80, 1'b0, 0);
        do8("w8_sra", OP_SRA, 8'h80, 8'h00, 3'd3, 8'hF0, 1'b0, 0);
        do8("w8_mul", OP_MUL, 8'hFD, 8'h07, 3'd0, 8'hEB, 1'b0, 9);
        do8("w8_mulovf", OP_MUL, 8'h10, 8'h10, 3'd0, 8'h00, 1'b1, 9);
        do8("w8_div", OP_DIV, 8'h80, 8'hFF, 3'd0, 8'h80, 1'b1, 9);

        repeat (2) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
